// File: rtl/goldilocks_limb_mul_pkg.sv
// Shared definitions for the Goldilocks arithmetic blocks (limb multiplier,
// fast reducer, NTT butterfly).
//   GOLDILOCKS_P : field modulus 2^64 - 2^32 + 1
//   LIMB_W/WORD_W: limb and field-word widths
//   state_t      : limb multiplier FSM states
//   step_t       : partial-product step index
package goldilocks_limb_mul_pkg;
  localparam logic [63:0] GOLDILOCKS_P = 64'hFFFF_FFFF_0000_0001;
  localparam int LIMB_W = 32;
  localparam int WORD_W = 64;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  typedef logic [1:0] step_t;
endpackage

// File: rtl/goldilocks_limb_mul_mul32x32.sv
// Combinational 32x32 -> 64 unsigned multiplier.
//   a, b : 32-bit operands
//   p    : 64-bit product
module goldilocks_limb_mul_mul32x32
  import goldilocks_limb_mul_pkg::*;
(
  input  logic [LIMB_W-1:0]   a,
  input  logic [LIMB_W-1:0]   b,
  output logic [2*LIMB_W-1:0] p
);
  assign p = {{LIMB_W{1'b0}}, a} * {{LIMB_W{1'b0}}, b};
endmodule

// File: rtl/goldilocks_limb_mul.sv
// Iterative 64x64 -> 128 multiplier producing four 32-bit limbs for the
// Goldilocks fast reducer. One 32x32 partial product is accumulated per cycle.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (x, y sampled at acceptance)
//   out_valid/out_ready : limb handshake, limbs held under backpressure
//   a,b,c,d             : product = a<<96 | b<<64 | c<<32 | d (registered)
//   busy                : high in MUL or DONE
module goldilocks_limb_mul
  import goldilocks_limb_mul_pkg::*;
#(
  parameter logic [WORD_W-1:0] P          = GOLDILOCKS_P,
  parameter bit                PRE_REDUCE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIMB_W-1:0] a,
  output logic [LIMB_W-1:0] b,
  output logic [LIMB_W-1:0] c,
  output logic [LIMB_W-1:0] d,
  output logic              busy
);
  state_t              state, state_nxt;
  step_t               step;
  logic [WORD_W-1:0]   xr, yr;
  logic [2*WORD_W-1:0] acc, pp_sh, acc_sum;
  logic [LIMB_W-1:0]   ma, mb;
  logic [WORD_W-1:0]   pp;

  // Any 64-bit value is < 2P, so one conditional subtraction fully reduces.
  function automatic logic [WORD_W-1:0] pre_red(input logic [WORD_W-1:0] v);
    if (PRE_REDUCE && (v >= P)) return v - P;
    return v;
  endfunction

  // step[1] picks the high half of x, step[0] the high half of y.
  assign ma = step[1] ? xr[WORD_W-1:LIMB_W] : xr[LIMB_W-1:0];
  assign mb = step[0] ? yr[WORD_W-1:LIMB_W] : yr[LIMB_W-1:0];

  goldilocks_limb_mul_mul32x32 u_mul (.a(ma), .b(mb), .p(pp));

  always_comb begin
    pp_sh = '0;
    case (step)
      2'd0:    pp_sh = {{WORD_W{1'b0}}, pp};
      2'd3:    pp_sh = {pp, {WORD_W{1'b0}}};
      default: pp_sh = {{LIMB_W{1'b0}}, pp, {LIMB_W{1'b0}}};
    endcase
  end

  // True product is < 2^128, so the 128-bit sum never overflows.
  assign acc_sum = acc + pp_sh;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = MUL;
      MUL:     if (step == 2'd3)  state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0;
      xr   <= '0;
      yr   <= '0;
      acc  <= '0;
      a    <= '0;
      b    <= '0;
      c    <= '0;
      d    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          xr   <= pre_red(x);
          yr   <= pre_red(y);
          acc  <= '0;
          step <= '0;
        end
        MUL: begin
          acc  <= acc_sum;
          step <= step + 2'd1;
          if (step == 2'd3) {a, b, c, d} <= acc_sum;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
endmodule
